// File: rtl/cuckoo_pkg.sv
// Shared definitions for the 3-ary cuckoo hash table and its overflow stash.
package cuckoo_pkg;

    localparam int unsigned KEY_WIDTH   = 27;
    localparam int unsigned VALUE_WIDTH = 32;
    localparam int unsigned TABLE_SIZE  = 1024;
    localparam int unsigned ARY_SIZE    = 3;

    localparam logic [KEY_WIDTH-1:0] EMPTY_KEY = '0;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } kv_pair;

endpackage

// File: rtl/cuckoo_stash_cam.sv
// Parallel key compare across all stash entries; one-hot match vector plus hit flag.
module cuckoo_stash_cam #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned KEY_W = 27
) (
    input  logic [DEPTH-1:0][KEY_W-1:0] i_keys,
    input  logic [DEPTH-1:0]            i_valid,
    input  logic [KEY_W-1:0]            i_key,
    output logic [DEPTH-1:0]            o_match,
    output logic                        o_hit
);
    import cuckoo_pkg::*;

    logic w_key_nz;
    assign w_key_nz = (i_key != KEY_W'(EMPTY_KEY));

    always_comb begin
        o_match = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            o_match[i] = w_key_nz && i_valid[i] && (i_keys[i] == i_key);
        end
    end

    assign o_hit = |o_match;

endmodule

// File: rtl/cuckoo_stash.sv
// Fully-associative FIFO stash catching cuckoo-table overflow: insert, lookup, oldest-first drain.
module cuckoo_stash #(
    parameter int unsigned STASH_DEPTH = 8,
    parameter int unsigned KEY_WIDTH   = cuckoo_pkg::KEY_WIDTH,
    parameter int unsigned VALUE_WIDTH = cuckoo_pkg::VALUE_WIDTH,
    parameter int unsigned CNT_W       = $clog2(STASH_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ins_valid,
    output logic                   ins_ready,
    input  logic [KEY_WIDTH-1:0]   ins_key,
    input  logic [VALUE_WIDTH-1:0] ins_value,
    input  logic                   lkp_valid,
    input  logic [KEY_WIDTH-1:0]   lkp_key,
    output logic                   lkp_done,
    output logic                   lkp_hit,
    output logic [VALUE_WIDTH-1:0] lkp_value,
    output logic                   drn_valid,
    input  logic                   drn_ready,
    output logic [KEY_WIDTH-1:0]   drn_key,
    output logic [VALUE_WIDTH-1:0] drn_value,
    output logic [CNT_W-1:0]       count,
    output logic                   overflow
);
    import cuckoo_pkg::*;

    localparam int unsigned PTR_W = $clog2(STASH_DEPTH);

    logic [STASH_DEPTH-1:0][KEY_WIDTH-1:0] r_keys;
    logic [VALUE_WIDTH-1:0]                r_vals [STASH_DEPTH];
    logic [STASH_DEPTH-1:0]                r_valid;
    logic [PTR_W-1:0]                      r_head, r_tail;
    logic [CNT_W-1:0]                      r_count;
    logic                                  r_overflow;
    logic                                  r_lkp_done, r_lkp_hit;
    logic [VALUE_WIDTH-1:0]                r_lkp_value;

    logic                   w_full, w_ins_fire, w_drn_fire, w_ins_nz;
    logic [STASH_DEPTH-1:0] w_ins_match, w_lkp_match, w_head_oh, w_upd_match;
    logic                   w_ins_hit, w_lkp_hit, w_do_upd, w_do_app;
    logic [VALUE_WIDTH-1:0] w_lkp_val;

    cuckoo_stash_cam #(.DEPTH(STASH_DEPTH), .KEY_W(KEY_WIDTH)) u_ins_cam (
        .i_keys  (r_keys),
        .i_valid (r_valid),
        .i_key   (ins_key),
        .o_match (w_ins_match),
        .o_hit   (w_ins_hit)
    );

    cuckoo_stash_cam #(.DEPTH(STASH_DEPTH), .KEY_W(KEY_WIDTH)) u_lkp_cam (
        .i_keys  (r_keys),
        .i_valid (r_valid),
        .i_key   (lkp_key),
        .o_match (w_lkp_match),
        .o_hit   (w_lkp_hit)
    );

    assign w_full     = (r_count == CNT_W'(STASH_DEPTH));
    assign ins_ready  = !w_full;
    assign drn_valid  = (r_count != '0);
    assign w_ins_fire = ins_valid && ins_ready;
    assign w_drn_fire = drn_valid && drn_ready;
    assign w_ins_nz   = (ins_key != KEY_WIDTH'(EMPTY_KEY));

    // A key matching the entry leaving this cycle is re-appended, not updated in place.
    assign w_head_oh   = w_drn_fire ? (STASH_DEPTH'(1) << r_head) : '0;
    assign w_upd_match = w_ins_match & ~w_head_oh;
    assign w_do_upd    = w_ins_fire && w_ins_nz && w_ins_hit && (w_upd_match != '0);
    assign w_do_app    = w_ins_fire && w_ins_nz && (w_upd_match == '0);

    always_comb begin
        w_lkp_val = '0;
        for (int i = 0; i < int'(STASH_DEPTH); i++) begin
            if (w_lkp_match[i]) w_lkp_val = w_lkp_val | r_vals[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_keys      <= '0;
            r_valid     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_lkp_done  <= 1'b0;
            r_lkp_hit   <= 1'b0;
            r_lkp_value <= '0;
            for (int i = 0; i < int'(STASH_DEPTH); i++) r_vals[i] <= '0;
        end else begin
            if (ins_valid && w_full) r_overflow <= 1'b1;
            if (w_drn_fire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_do_app) begin
                r_valid[r_tail] <= 1'b1;
                r_keys[r_tail]  <= ins_key;
                r_vals[r_tail]  <= ins_value;
                r_tail          <= r_tail + PTR_W'(1);
            end
            for (int i = 0; i < int'(STASH_DEPTH); i++) begin
                if (w_do_upd && w_upd_match[i]) r_vals[i] <= ins_value;
            end
            r_count    <= r_count + CNT_W'(w_do_app) - CNT_W'(w_drn_fire);
            r_lkp_done <= lkp_valid;
            if (lkp_valid) begin
                r_lkp_hit   <= w_lkp_hit;
                r_lkp_value <= w_lkp_val;
            end
        end
    end

    assign drn_key   = drn_valid ? r_keys[r_head] : '0;
    assign drn_value = drn_valid ? r_vals[r_head] : '0;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign lkp_done  = r_lkp_done;
    assign lkp_hit   = r_lkp_hit;
    assign lkp_value = r_lkp_value;

endmodule

// File: tb/tb_cuckoo_stash.sv
// Self-checking bench for cuckoo_stash against a queue-based FIFO/dictionary model.
module tb_cuckoo_stash;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ins_valid = 1'b0, ins_ready;
    logic [26:0] ins_key = '0;
    logic [31:0] ins_value = '0;
    logic        lkp_valid = 1'b0;
    logic [26:0] lkp_key = '0;
    logic        lkp_done, lkp_hit;
    logic [31:0] lkp_value;
    logic        drn_valid, drn_ready = 1'b0;
    logic [26:0] drn_key;
    logic [31:0] drn_value;
    logic [3:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    cuckoo_pkg::kv_pair q[$];
    logic        exp_ovf = 1'b0;
    logic        exp_hit = 1'b0;
    logic [31:0] exp_val = '0;

    cuckoo_stash #(.STASH_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_key   (ins_key),
        .ins_value (ins_value),
        .lkp_valid (lkp_valid),
        .lkp_key   (lkp_key),
        .lkp_done  (lkp_done),
        .lkp_hit   (lkp_hit),
        .lkp_value (lkp_value),
        .drn_valid (drn_valid),
        .drn_ready (drn_ready),
        .drn_key   (drn_key),
        .drn_value (drn_value),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic int find(input logic [26:0] k);
        if (k == 27'd0) return -1;
        for (int i = 0; i < q.size(); i++) if (q[i].key == k) return i;
        return -1;
    endfunction

    // One clock: drive, check combinational state, advance model, check registered results.
    task automatic step(input logic iv, input logic [26:0] ik, input logic [31:0] ivl,
                        input logic lv, input logic [26:0] lk, input logic dr);
        int idx;
        logic full;
        logic [26:0] ek;
        logic [31:0] ev;
        ins_valid = iv; ins_key = ik; ins_value = ivl;
        lkp_valid = lv; lkp_key = lk; drn_ready = dr;
        #1;
        full = (q.size() == DEPTH);
        ek = (q.size() != 0) ? q[0].key : 27'd0;
        ev = (q.size() != 0) ? q[0].value : 32'd0;
        checks++;
        if (ins_ready !== !full) begin
            errors++; $display("FAIL ins_ready got %b want %b", ins_ready, !full);
        end
        checks++;
        if (drn_valid !== (q.size() != 0)) begin
            errors++; $display("FAIL drn_valid got %b want %b", drn_valid, q.size() != 0);
        end
        checks++;
        if (drn_key !== ek || drn_value !== ev) begin
            errors++;
            $display("FAIL drn_head got %h/%h want %h/%h", drn_key, drn_value, ek, ev);
        end
        checks++;
        if (count !== 4'(q.size())) begin
            errors++; $display("FAIL count got %0d want %0d", count, q.size());
        end
        if (lv) begin
            idx = find(lk);
            exp_hit = (idx >= 0);
            exp_val = (idx >= 0) ? q[idx].value : 32'd0;
        end
        if (iv && full) exp_ovf = 1'b1;
        if (dr && q.size() != 0) void'(q.pop_front());
        if (iv && !full && ik != 27'd0) begin
            idx = find(ik);
            if (idx >= 0) q[idx].value = ivl;
            else q.push_back('{key: ik, value: ivl});
        end
        @(posedge clk); #1;
        checks++;
        if (lkp_done !== lv) begin
            errors++; $display("FAIL lkp_done got %b want %b", lkp_done, lv);
        end
        checks++;
        if (lkp_hit !== exp_hit || lkp_value !== exp_val) begin
            errors++;
            $display("FAIL lkp_result got %b/%h want %b/%h", lkp_hit, lkp_value, exp_hit, exp_val);
        end
        checks++;
        if (overflow !== exp_ovf) begin
            errors++; $display("FAIL overflow got %b want %b", overflow, exp_ovf);
        end
        ins_valid = 1'b0; lkp_valid = 1'b0; drn_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        q.delete();
        exp_ovf = 1'b0; exp_hit = 1'b0; exp_val = '0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (count !== 4'd0 || drn_valid !== 1'b0 || lkp_done !== 1'b0 || lkp_hit !== 1'b0
            || lkp_value !== 32'd0 || overflow !== 1'b0 || ins_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got cnt=%0d dv=%b ld=%b lh=%b lv=%h ov=%b ir=%b want 0,0,0,0,0,0,1",
                     count, drn_valid, lkp_done, lkp_hit, lkp_value, overflow, ins_ready);
        end
        do_reset();
    endtask

    task automatic test_basic();
        step(1, 27'h11, 32'hA1, 0, 0, 0);
        step(1, 27'h22, 32'hA2, 0, 0, 0);
        step(1, 27'h33, 32'hA3, 0, 0, 0);
        checks++;
        if (count !== 4'd3 || drn_key !== 27'h11 || drn_value !== 32'hA1) begin
            errors++;
            $display("FAIL basic_head got %0d %h %h want 3 11 a1", count, drn_key, drn_value);
        end
        step(0, 0, 0, 1, 27'h22, 0);
        checks++;
        if (lkp_hit !== 1'b1 || lkp_value !== 32'hA2) begin
            errors++; $display("FAIL basic_lookup got %b %h want 1 a2", lkp_hit, lkp_value);
        end
    endtask

    task automatic test_dup();
        logic [26:0] order [3];
        order[0] = 27'h11; order[1] = 27'h22; order[2] = 27'h33;
        step(1, 27'h22, 32'hBEEF, 0, 0, 0);
        step(0, 0, 0, 1, 27'h22, 0);
        checks++;
        if (count !== 4'd3 || lkp_value !== 32'hBEEF) begin
            errors++; $display("FAIL dup_update got %0d %h want 3 beef", count, lkp_value);
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (drn_key !== order[i]) begin
                errors++; $display("FAIL dup_order got %h want %h", drn_key, order[i]);
            end
            step(0, 0, 0, 0, 0, 1);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 27'h51 + 27'(i), 32'h100 + 32'(i), 0, 0, 0);
        step(1, 27'h99, 32'h999, 0, 0, 0);
        checks++;
        if (overflow !== 1'b1 || count !== 4'd8 || ins_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_refuse got ov=%b cnt=%0d ir=%b want 1 8 0", overflow, count, ins_ready);
        end
        step(0, 0, 0, 1, 27'h99, 0);
        step(1, 27'h99, 32'h999, 0, 0, 1);
        checks++;
        if (count !== 4'd7 || overflow !== 1'b1) begin
            errors++; $display("FAIL full_drain_ins got %0d %b want 7 1", count, overflow);
        end
        step(0, 0, 0, 1, 27'h99, 0);
    endtask

    task automatic test_simul();
        do_reset();
        step(1, 27'h11, 32'h1, 0, 0, 0);
        step(1, 27'h22, 32'h2, 0, 0, 0);
        step(1, 27'h44, 32'h4, 0, 0, 1);
        checks++;
        if (count !== 4'd2 || drn_key !== 27'h22) begin
            errors++; $display("FAIL simul_count got %0d %h want 2 22", count, drn_key);
        end
        // Insert of the key being drained re-appends it at the tail.
        step(1, 27'h22, 32'h222, 0, 0, 1);
        for (int i = 0; i < 10; i++)
            step(1, 27'h60 + 27'(i), 32'h600 + 32'(i), 1, 27'h22, (i % 3) != 0);
        while (q.size() != 0) step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_zero();
        step(1, 27'h5, 32'h55, 0, 0, 0);
        step(1, 27'h0, 32'hDEAD, 1, 27'h0, 0);
        checks++;
        if (count !== 4'd1 || lkp_hit !== 1'b0 || lkp_value !== 32'd0) begin
            errors++;
            $display("FAIL zero_key got %0d %b %h want 1 0 0", count, lkp_hit, lkp_value);
        end
        step(0, 0, 0, 1, 27'h0, 0);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 9) < 6, 27'($urandom_range(0, 12)), $urandom,
                 $urandom_range(0, 1), 27'($urandom_range(0, 12)), $urandom_range(0, 9) < 4);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 27'h71 + 27'(i), 32'h700 + 32'(i), 0, 0, 0);
        step(1, 27'h99, 32'h1, 0, 0, 1);
        drn_ready = 1'b1; lkp_valid = 1'b1; lkp_key = 27'h72;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || drn_valid !== 1'b0 || lkp_done !== 1'b0 || overflow !== 1'b0
            || lkp_hit !== 1'b0 || lkp_value !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid got cnt=%0d dv=%b ld=%b ov=%b lh=%b want all 0",
                     count, drn_valid, lkp_done, overflow, lkp_hit);
        end
        drn_ready = 1'b0; lkp_valid = 1'b0;
        q.delete();
        exp_ovf = 1'b0; exp_hit = 1'b0; exp_val = '0;
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (lkp_done !== 1'b0) begin
            errors++; $display("FAIL reset_release_pulse got %b want 0", lkp_done);
        end
        step(0, 0, 0, 1, 27'h72, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dup();
        test_full();
        test_simul();
        test_zero();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cuckoo_stash.md
Name: cuckoo_stash

Overview:
- Small fully-associative overflow buffer that sits directly downstream of the 3-ary cuckoo hash table.
- Captures each key/value pair the table rejects on collision, so the pair is not lost.
- Answers lookups for stashed keys in parallel with the table lookup.
- Drains stashed entries oldest-first back to the table's insert path for re-insertion.

Parameters:
- STASH_DEPTH, 8, number of entries (power of two, 2..32)
- KEY_WIDTH, 27, key width; key value 0 is reserved as "empty", consistent with the table
- VALUE_WIDTH, 32, value width
- CNT_W, $clog2(STASH_DEPTH+1), occupancy counter width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ins_valid  in  1  table presents an overflowed pair
- ins_ready  out  1  stash can accept an insert
- ins_key  in  KEY_WIDTH  key to stash
- ins_value  in  VALUE_WIDTH  value to stash
- lkp_valid  in  1  lookup request
- lkp_key  in  KEY_WIDTH  lookup key
- lkp_done  out  1  lookup result valid (one-cycle pulse)
- lkp_hit  out  1  key found in stash
- lkp_value  out  VALUE_WIDTH  value on hit, else 0
- drn_valid  out  1  oldest entry available for re-insertion
- drn_ready  in  1  table accepts drained entry
- drn_key  out  KEY_WIDTH  oldest entry key
- drn_value  out  VALUE_WIDTH  oldest entry value
- count  out  CNT_W  current occupancy
- overflow  out  1  sticky: insert attempted while full

Behaviour:
- Reset (rst low, asynchronous): all entries invalid, key/value arrays cleared, head=tail=count=0; lkp_done=0, lkp_hit=0, lkp_value=0, overflow=0. Reset mid-operation discards all contents and in-flight lookups; no pulse is emitted on release.
- Storage: circular buffer of STASH_DEPTH entries; head = oldest, tail = next free; head and tail pointers wrap modulo STASH_DEPTH.
- ins_ready = (count != STASH_DEPTH). It is combinational from count only and has no dependence on drn_ready.
- Insert handshake is ins_valid && ins_ready. An insert with ins_key == 0 is accepted and silently dropped: no state change.
- Duplicate key: if ins_key matches a valid entry, that entry's value is overwritten in place; tail and count are unchanged.
- New key: written at tail; tail increments, count increments.
- Full insert: ins_valid && !ins_ready sets overflow=1. overflow stays set until reset; nothing is written.
- Drain: drn_valid = (count != 0). drn_key and drn_value are taken combinationally from the head entry and are 0 when empty. On drn_valid && drn_ready, head is invalidated, head increments, count decrements.
- Simultaneous insert and drain:
  - Both take effect in the same cycle; count is unchanged.
  - If the insert key matches the entry being drained, the insert is treated as a new append at tail, not as an in-place update.
  - When full, ins_ready stays 0 in the drain cycle; the insert is refused and overflow is set.
- Lookup: registered, latency 1.
  - On lkp_valid, lkp_key is compared against all valid entries using pre-update state (a same-cycle insert is not visible).
  - Next cycle: lkp_done=1; on a match, lkp_hit=1 and lkp_value = the entry's value; on a miss, lkp_hit=0 and lkp_value=0.
  - lkp_key == 0 always misses.
  - lkp_done is 0 in cycles without a request. lkp_hit and lkp_value hold their last value when lkp_done=0.
  - Back-to-back lookups are supported every cycle.
- Keys are unique among valid entries, so at most one entry can match.

Decomposition:
- Shared package cuckoo_pkg: KEY_WIDTH, VALUE_WIDTH, TABLE_SIZE, ARY_SIZE, EMPTY_KEY=0, and a kv_pair struct {key, value}. The hash table and the stash both import it.
- One sub-module, cuckoo_stash_cam: parameterised parallel key compare that returns a one-hot match vector plus a hit bit. It is used twice, once for lookup and once for insert duplicate detection.

Test Plan:
- Reset, then insert keys 0x11, 0x22, 0x33 with values 0xA1, 0xA2, 0xA3 -> count=3; drn_key=0x11, drn_value=0xA1; lookup 0x22 gives lkp_done=1, lkp_hit=1, lkp_value=0xA2 one cycle later.
- Insert key 0x22 with value 0xBEEF while present -> count stays 3; lookup 0x22 returns 0xBEEF; drain order remains 0x11, 0x22, 0x33.
- Fill to 8 entries, then assert ins_valid with key 0x99 -> ins_ready=0, overflow=1 and sticky; lookup 0x99 misses. Then drain one entry with a simultaneous insert of 0x99 -> insert refused, count=7.
- With count=2, assert insert 0x44 and drain handshake in the same cycle -> count=2, head advances, 0x44 is at tail. After 10 mixed ops, pointers wrap and drain order is preserved.
- Insert key 0 and lookup key 0 -> no state change, count unchanged; lookup returns lkp_hit=0, lkp_value=0.
- Pull rst low mid-drain with 5 entries -> count=0, drn_valid=0, lkp_done=0, overflow=0 immediately; lookup of a previously stashed key misses after release.
